// File: rtl/wts_mixer_pkg.sv
// Shared types and widths for the wave-table channel mixer.
// Imported by the volume multiplier stage and the mixer top.
package wts_mixer_pkg;

  localparam int WAVE_W = 8;
  localparam int VOL_W  = 4;
  localparam int PROD_W = 13;
  localparam int OUT_W  = 11;

  typedef logic signed [PROD_W-1:0] wts_product_t;
  typedef logic [2:0] wts_slot_t;

  typedef struct packed {
    logic         valid;
    wts_slot_t    slot;
    wts_product_t product;
  } wts_s1_t;

endpackage

// File: rtl/wts_volume_multiplier.sv
// Stage 1: selects the slot's volume/enable and scales the sample.
// Registers the product together with its valid flag and slot index.
module wts_volume_multiplier
  import wts_mixer_pkg::*;
#(
  parameter int CHANNELS = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sample_valid,
  input  wts_slot_t                sample_slot,
  input  logic signed [WAVE_W-1:0] wave_data,
  input  logic [VOL_W-1:0]         reg_volume_a,
  input  logic [VOL_W-1:0]         reg_volume_b,
  input  logic [VOL_W-1:0]         reg_volume_c,
  input  logic [VOL_W-1:0]         reg_volume_d,
  input  logic [VOL_W-1:0]         reg_volume_e,
  input  logic [4:0]               reg_enable,
  output wts_s1_t                  s1
);

  logic [VOL_W-1:0] vol;
  logic             en;
  wts_product_t     wave_ext;
  wts_product_t     vol_ext;
  wts_product_t     product;
  logic             slot_ok;

  // Pick this slot's volume and enable; unknown slots stay silent.
  always_comb begin
    vol = '0;
    en  = 1'b0;
    unique case (sample_slot)
      3'd0: begin vol = reg_volume_a; en = reg_enable[0]; end
      3'd1: begin vol = reg_volume_b; en = reg_enable[1]; end
      3'd2: begin vol = reg_volume_c; en = reg_enable[2]; end
      3'd3: begin vol = reg_volume_d; en = reg_enable[3]; end
      3'd4: begin vol = reg_volume_e; en = reg_enable[4]; end
      default: begin vol = '0; en = 1'b0; end
    endcase
  end

  // Volume is unsigned, so zero-extend it before the signed multiply.
  assign wave_ext = wts_product_t'(wave_data);
  assign vol_ext  = wts_product_t'({1'b0, vol});
  assign product  = en ? wave_ext * vol_ext : '0;
  assign slot_ok  = 32'(sample_slot) < CHANNELS;

  // Pipeline register for the scaled sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
    end else begin
      s1.valid   <= sample_valid & slot_ok;
      s1.slot    <= sample_slot;
      s1.product <= product;
    end
  end

endmodule

// File: rtl/wts_channel_mixer.sv
// Per-frame mixer: accumulates scaled slots and emits one sample per frame.
// Optional output low-pass filter enabled by defining WTS_MIXER_LPF_EN.
module wts_channel_mixer
  import wts_mixer_pkg::*;
#(
  parameter int CHANNELS  = 5,
  parameter int ACC_W     = 15,
  parameter int OUT_SHIFT = 4
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     sample_valid,
  input  logic [2:0]               sample_slot,
  input  logic signed [WAVE_W-1:0] wave_data,
  input  logic [VOL_W-1:0]         reg_volume_a,
  input  logic [VOL_W-1:0]         reg_volume_b,
  input  logic [VOL_W-1:0]         reg_volume_c,
  input  logic [VOL_W-1:0]         reg_volume_d,
  input  logic [VOL_W-1:0]         reg_volume_e,
  input  logic [4:0]               reg_enable,
  output logic signed [OUT_W-1:0]  sound_out,
  output logic                     sound_valid
);

  logic [1:0]               rst_q;
  logic                     rst_n;
  wts_s1_t                  s1;
  wts_product_t             s1_prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  frame_sum;
  logic signed [OUT_W-1:0]  mix_out;
  logic signed [OUT_W-1:0]  next_out;
  logic                     frame_close;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rst_q <= '0;
    end else begin
      rst_q <= {rst_q[0], 1'b1};
    end
  end

  assign rst_n = rst_q[1];

  wts_volume_multiplier #(
    .CHANNELS (CHANNELS)
  ) u_mult (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample_slot  (sample_slot),
    .wave_data    (wave_data),
    .reg_volume_a (reg_volume_a),
    .reg_volume_b (reg_volume_b),
    .reg_volume_c (reg_volume_c),
    .reg_volume_d (reg_volume_d),
    .reg_volume_e (reg_volume_e),
    .reg_enable   (reg_enable),
    .s1           (s1)
  );

  assign s1_prod     = s1.product;
  assign prod_ext    = ACC_W'(s1_prod);
  assign frame_sum   = acc + prod_ext;
  assign frame_close = s1.valid & (32'(s1.slot) == CHANNELS - 1);
  assign mix_out     = OUT_W'(frame_sum >>> OUT_SHIFT);

`ifdef WTS_MIXER_LPF_EN
  localparam int LPF_W = OUT_W + 1;
  logic signed [LPF_W-1:0] lpf_diff;
  assign lpf_diff = LPF_W'(mix_out) - LPF_W'(sound_out);
  assign next_out = OUT_W'(LPF_W'(sound_out) + (lpf_diff >>> 2));
`else
  assign next_out = mix_out;
`endif

  // Slot 0 restarts the frame; other valid slots add in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (s1.valid) begin
      acc <= (s1.slot == 3'd0) ? prod_ext : frame_sum;
    end
  end

  // Last slot closes the frame and strobes the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sound_out   <= '0;
      sound_valid <= 1'b0;
    end else begin
      sound_valid <= frame_close;
      if (frame_close) begin
        sound_out <= next_out;
      end
    end
  end

endmodule

// File: tb/tb_wts_channel_mixer.sv
// Scoreboard bench for wts_channel_mixer.
// Expected frame values are hand-computed; filter model follows WTS_MIXER_LPF_EN.
module tb_wts_channel_mixer;

  logic              clk = 1'b0;
  logic              nreset = 1'b0;
  logic              sample_valid = 1'b0;
  logic [2:0]        sample_slot = '0;
  logic signed [7:0] wave_data = '0;
  logic [3:0]        reg_volume_a = '0;
  logic [3:0]        reg_volume_b = '0;
  logic [3:0]        reg_volume_c = '0;
  logic [3:0]        reg_volume_d = '0;
  logic [3:0]        reg_volume_e = '0;
  logic [4:0]        reg_enable = '0;
  logic signed [10:0] sound_out;
  logic              sound_valid;

  wts_channel_mixer dut (
    .clk          (clk),
    .nreset       (nreset),
    .sample_valid (sample_valid),
    .sample_slot  (sample_slot),
    .wave_data    (wave_data),
    .reg_volume_a (reg_volume_a),
    .reg_volume_b (reg_volume_b),
    .reg_volume_c (reg_volume_c),
    .reg_volume_d (reg_volume_d),
    .reg_volume_e (reg_volume_e),
    .reg_enable   (reg_enable),
    .sound_out    (sound_out),
    .sound_valid  (sound_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         checks = 0;
  int         fails = 0;
  int         exp_state = 0;
  bit         mon_en = 0;
  logic [3:0] vol_n[5];
  logic [4:0] en_n = 5'h1f;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act,
                       input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every output strobe must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && sound_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_valid: got %0d, expected none",
                   sound_out);
        end else begin
          e = sb.pop_front();
          check("sound_out", int'(sound_out), e.val);
          check("latency_cycle", cyc, e.due);
        end
      end
    end
  end

  task automatic set_vols(input int a, input int b, input int c,
                          input int d, input int e);
    vol_n[0] = 4'(a);
    vol_n[1] = 4'(b);
    vol_n[2] = 4'(c);
    vol_n[3] = 4'(d);
    vol_n[4] = 4'(e);
  endtask

  task automatic drive(input int slot, input int wave);
    @(posedge clk);
    #1;
    sample_valid = 1'b1;
    sample_slot  = 3'(slot);
    wave_data    = 8'(wave);
    reg_volume_a = vol_n[0];
    reg_volume_b = vol_n[1];
    reg_volume_c = vol_n[2];
    reg_volume_d = vol_n[3];
    reg_volume_e = vol_n[4];
    reg_enable   = en_n;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      wave_data    = 8'sh55;
    end
  endtask

  // Push the expected output for a frame whose raw mix is raw.
  task automatic expect_frame(input int raw);
    exp_t e;
`ifdef WTS_MIXER_LPF_EN
    exp_state = exp_state + ((raw - exp_state) >>> 2);
`else
    exp_state = raw;
`endif
    e.val = exp_state;
    e.due = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic frame(input int wave, input int raw);
    for (int s = 0; s < 5; s++) begin
      drive(s, wave);
      if (s == 4) expect_frame(raw);
    end
  endtask

  initial begin
    int bad;
    int wait_n;
    set_vols(15, 15, 15, 15, 15);
    // Reset held with activity on the inputs.
    sample_valid = 1'b1;
    sample_slot  = 3'd4;
    wave_data    = 8'sd127;
    reg_volume_e = 4'd15;
    reg_enable   = 5'h1f;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sound_out !== '0 || sound_valid !== 1'b0) bad++;
    end
    check("reset_hold_violations", bad, 0);
    sample_valid = 1'b0;
    nreset = 1'b1;
    idle(5);
    check("post_reset_out", int'(sound_out), 0);
    mon_en = 1;

    // Full scale positive, then negative, back to back.
    en_n = 5'h1f;
    set_vols(15, 15, 15, 15, 15);
    frame(127, 595);
    frame(-128, -600);
    idle(3);

    // Only channel 0 enabled.
    en_n = 5'b00001;
    set_vols(8, 15, 15, 15, 15);
    frame(100, 50);
    idle(2);

    // Partial frame dropped by a new slot 0.
    en_n = 5'h1f;
    set_vols(15, 15, 15, 15, 15);
    for (int s = 0; s < 3; s++) drive(s, 64);
    set_vols(1, 1, 1, 1, 1);
    frame(16, 5);
    idle(2);

    // Mixed volumes: 32 * (1+2+3+4+5) = 480.
    set_vols(1, 2, 3, 4, 5);
    frame(32, 30);
    idle(2);

    // Missing slots, gaps and out-of-range slots.
    set_vols(15, 15, 15, 15, 15);
    drive(0, 127);
    idle(2);
    drive(6, 127);
    drive(5, -128);
    idle(1);
    drive(4, 127);
    expect_frame(238);
    idle(2);

    // Small negative sum floors to -1.
    en_n = 5'b00001;
    set_vols(1, 15, 15, 15, 15);
    frame(-1, -1);
    idle(2);

    // Zero volume everywhere.
    en_n = 5'h1f;
    set_vols(0, 0, 0, 0, 0);
    frame(127, 0);
    idle(2);

    // Duplicate slot 1 accumulates: 6 * 16 = 96.
    set_vols(1, 1, 1, 1, 1);
    drive(0, 16);
    drive(1, 16);
    drive(1, 16);
    drive(2, 16);
    drive(3, 16);
    drive(4, 16);
    expect_frame(6);
    idle(4);

    // Reset mid-frame, then a clean frame.
    set_vols(15, 15, 15, 15, 15);
    for (int s = 0; s < 3; s++) drive(s, 64);
    #2;
    nreset = 1'b0;
    exp_state = 0;
    idle(3);
    check("midreset_out", int'(sound_out), 0);
    check("midreset_valid", int'(sound_valid), 0);
    nreset = 1'b1;
    idle(4);
    frame(127, 595);
    idle(1);

    wait_n = 0;
    while (sb.size() != 0 && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check("scoreboard_drained", sb.size(), 0);
    idle(4);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
